// File: rtl/datapath_seq_if.sv
// Bundles the request fields, operand sources and results of datapath_seq.
// The master side issues operations; the slave side is the datapath.
interface datapath_seq_if #(
  parameter int W   = 16,
  parameter int RAW = 3,
  parameter int PCW = 8
);
  logic           start;
  logic [RAW-1:0] rn;
  logic [RAW-1:0] rm;
  logic [RAW-1:0] rd;
  logic [1:0]     shift;
  logic [1:0]     aluop;
  logic           asel;
  logic           bsel;
  logic [3:0]     vsel;
  logic           wb_en;
  logic           ld_s;
  logic [W-1:0]   mdata;
  logic [W-1:0]   sximm8;
  logic [W-1:0]   sximm5;
  logic [PCW-1:0] pc;
  logic           busy;
  logic           done;
  logic           err;
  logic [W-1:0]   c_out;
  logic [2:0]     status;
  logic [RAW-1:0] dbg_addr;
  logic [W-1:0]   dbg_data;

  modport master (
    output start, rn, rm, rd, shift, aluop, asel, bsel, vsel, wb_en, ld_s,
           mdata, sximm8, sximm5, pc, dbg_addr,
    input  busy, done, err, c_out, status, dbg_data
  );

  modport slave (
    input  start, rn, rm, rd, shift, aluop, asel, bsel, vsel, wb_en, ld_s,
           mdata, sximm8, sximm5, pc, dbg_addr,
    output busy, done, err, c_out, status, dbg_data
  );
endinterface

// File: rtl/datapath_seq.sv
// Multi-cycle register-file datapath: read A, read B, execute, write back.
//
//   state | meaning
//   IDLE  | waiting for start; only state that accepts a request
//   LDA   | A <= reg[rn]
//   LDB   | B <= reg[rm]
//   EXE   | C and (optionally) status loaded from the ALU
//   WB    | done/err pulse; reg[rd] written on the edge that leaves WB
module datapath_seq #(
  parameter int W   = 16,
  parameter int RAW = 3,
  parameter int PCW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  datapath_seq_if.slave bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LDA  = 3'd1;
  localparam logic [2:0] LDB  = 3'd2;
  localparam logic [2:0] EXE  = 3'd3;
  localparam logic [2:0] WB   = 3'd4;

  localparam int NREG = 2 ** RAW;

  logic [2:0]     state, state_nxt;
  logic [W-1:0]   rf [NREG];
  logic [W-1:0]   reg_a, reg_b, reg_c;
  logic [2:0]     status_q;

  logic [RAW-1:0] ir_rn, ir_rm, ir_rd;
  logic [1:0]     ir_shift, ir_aluop;
  logic           ir_asel, ir_bsel, ir_wb_en, ir_ld_s;
  logic [3:0]     ir_vsel;

  logic [W-1:0]   b_shifted, ain, bin, alu_res, sum, diff, wb_data;
  logic           alu_v, vsel_ok, wb_write;

  wire accept = (state == IDLE) && bus.start;

  // Next-state: a fixed five-step walk once a request is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LDA;
      LDA:     state_nxt = LDB;
      LDB:     state_nxt = EXE;
      EXE:     state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Instruction register: freezes control fields so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_rn    <= '0;
      ir_rm    <= '0;
      ir_rd    <= '0;
      ir_shift <= '0;
      ir_aluop <= '0;
      ir_asel  <= 1'b0;
      ir_bsel  <= 1'b0;
      ir_vsel  <= '0;
      ir_wb_en <= 1'b0;
      ir_ld_s  <= 1'b0;
    end else if (accept) begin
      ir_rn    <= bus.rn;
      ir_rm    <= bus.rm;
      ir_rd    <= bus.rd;
      ir_shift <= bus.shift;
      ir_aluop <= bus.aluop;
      ir_asel  <= bus.asel;
      ir_bsel  <= bus.bsel;
      ir_vsel  <= bus.vsel;
      ir_wb_en <= bus.wb_en;
      ir_ld_s  <= bus.ld_s;
    end
  end

  // B-operand shifter.
  always_comb begin
    b_shifted = reg_b;
    case (ir_shift)
      2'b01:   b_shifted = {reg_b[W-2:0], 1'b0};
      2'b10:   b_shifted = {1'b0, reg_b[W-1:1]};
      2'b11:   b_shifted = {reg_b[W-1], reg_b[W-1:1]};
      default: b_shifted = reg_b;
    endcase
  end

  // ALU with signed-overflow detection for add and subtract.
  always_comb begin
    ain     = ir_asel ? '0 : reg_a;
    bin     = ir_bsel ? bus.sximm5 : b_shifted;
    sum     = ain + bin;
    diff    = ain - bin;
    alu_res = sum;
    alu_v   = 1'b0;
    case (ir_aluop)
      2'b00: begin
        alu_res = sum;
        alu_v   = (ain[W-1] == bin[W-1]) && (sum[W-1] != ain[W-1]);
      end
      2'b01: begin
        alu_res = diff;
        alu_v   = (ain[W-1] != bin[W-1]) && (diff[W-1] != ain[W-1]);
      end
      2'b10:   alu_res = ain & bin;
      default: alu_res = ~bin;
    endcase
  end

  // Writeback source select; an invalid select suppresses the write and raises err.
  always_comb begin
    vsel_ok = $onehot(ir_vsel);
    wb_data = reg_c;
    case (ir_vsel)
      4'b0001: wb_data = bus.mdata;
      4'b0010: wb_data = bus.sximm8;
      4'b0100: wb_data = W'(bus.pc);
      default: wb_data = reg_c;
    endcase
    wb_write = (state == WB) && ir_wb_en && vsel_ok;
  end

  // Operand, result and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a    <= '0;
      reg_b    <= '0;
      reg_c    <= '0;
      status_q <= '0;
    end else begin
      if (state == LDA) reg_a <= rf[ir_rn];
      if (state == LDB) reg_b <= rf[ir_rm];
      if (state == EXE) begin
        reg_c <= alu_res;
        if (ir_ld_s) status_q <= {alu_v, alu_res[W-1], (alu_res == '0)};
      end
    end
  end

  // Register file; the only writer is WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_write) begin
      rf[ir_rd] <= wb_data;
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == WB);
  assign bus.err      = (state == WB) && ir_wb_en && !vsel_ok;
  assign bus.c_out    = reg_c;
  assign bus.status   = status_q;
  assign bus.dbg_data = rf[bus.dbg_addr];

endmodule

// File: tb/tb_datapath_seq.sv
// Directed plus randomized checks of datapath_seq against an arithmetic model.
module tb_datapath_seq;
  localparam int W   = 16;
  localparam int RAW = 3;
  localparam int PCW = 8;
  localparam int NREG = 2 ** RAW;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] m_rf [NREG];
  logic [W-1:0] m_c;
  logic [2:0]   m_st;

  datapath_seq_if #(.W(W), .RAW(RAW), .PCW(PCW)) bus ();
  datapath_seq #(.W(W), .RAW(RAW), .PCW(PCW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sval(input longint x);
    return (x >= (64'sd1 <<< (W - 1))) ? x - (64'sd1 <<< W) : x;
  endfunction

  // Reference ALU: plain integer arithmetic on signed interpretations.
  task automatic model_alu(input logic [W-1:0] a, b, input logic [1:0] sh, op,
                           input bit as, bs, input logic [W-1:0] s5,
                           output logic [W-1:0] res, output bit v);
    longint mask = (64'sd1 <<< W) - 1;
    longint ai, bsh, bi, full;
    ai = as ? 0 : longint'(a);
    case (sh)
      2'd1:    bsh = (longint'(b) * 2) & mask;
      2'd2:    bsh = longint'(b) / 2;
      2'd3:    bsh = (sval(longint'(b)) >>> 1) & mask;
      default: bsh = longint'(b);
    endcase
    bi = bs ? longint'(s5) : bsh;
    v  = 1'b0;
    case (op)
      2'd0: begin
        full = sval(ai) + sval(bi);
        v    = (full > (64'sd1 <<< (W - 1)) - 1) || (full < -(64'sd1 <<< (W - 1)));
        res  = W'(full & mask);
      end
      2'd1: begin
        full = sval(ai) - sval(bi);
        v    = (full > (64'sd1 <<< (W - 1)) - 1) || (full < -(64'sd1 <<< (W - 1)));
        res  = W'(full & mask);
      end
      2'd2:    res = W'(ai & bi);
      default: res = W'(mask - bi);
    endcase
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREG; i++) begin
      bus.dbg_addr = RAW'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), bus.dbg_data, m_rf[i]);
    end
  endtask

  // One full operation: issue, scramble captured fields, check every phase.
  task automatic run_op(input string tag, input logic [RAW-1:0] rn, rm, rd,
                        input logic [1:0] sh, op, input bit as, bs,
                        input logic [3:0] vs, input bit we, ls,
                        input logic [W-1:0] md, s8, s5, input logic [PCW-1:0] pcv,
                        input bit poke);
    logic [W-1:0] res, src;
    bit v, exp_err, ok;
    @(negedge clk);
    bus.rn = rn; bus.rm = rm; bus.rd = rd; bus.shift = sh; bus.aluop = op;
    bus.asel = as; bus.bsel = bs; bus.vsel = vs; bus.wb_en = we; bus.ld_s = ls;
    bus.mdata = md; bus.sximm8 = s8; bus.sximm5 = s5; bus.pc = pcv;
    bus.start = 1'b1;
    model_alu(m_rf[rn], m_rf[rm], sh, op, as, bs, s5, res, v);
    m_c = res;
    if (ls) m_st = {v, res[W-1], (res == '0)};
    ok      = ($countones(vs) == 1);
    exp_err = we && !ok;
    src = (vs == 4'b0001) ? md : (vs == 4'b0010) ? s8 : (vs == 4'b0100) ? W'(pcv) : res;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy_lda"}, bus.busy, 1);
    chk({tag, "_done_lda"}, bus.done, 0);
    bus.rn = RAW'($urandom); bus.rm = RAW'($urandom); bus.rd = RAW'($urandom);
    bus.shift = 2'($urandom); bus.aluop = 2'($urandom); bus.asel = 1'($urandom);
    bus.bsel = 1'($urandom); bus.vsel = 4'($urandom); bus.wb_en = 1'($urandom);
    bus.ld_s = 1'($urandom);
    @(negedge clk);
    chk({tag, "_busy_ldb"}, bus.busy, 1);
    if (poke) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy_exe"}, bus.busy, 1);
    @(negedge clk);
    chk({tag, "_done_wb"}, bus.done, 1);
    chk({tag, "_err_wb"}, bus.err, exp_err);
    chk({tag, "_c_out"}, bus.c_out, m_c);
    chk({tag, "_status"}, bus.status, m_st);
    if (we && ok) m_rf[rd] = src;
    @(negedge clk);
    chk({tag, "_busy_idle"}, bus.busy, 0);
    chk({tag, "_done_idle"}, bus.done, 0);
    chk({tag, "_err_idle"}, bus.err, 0);
    bus.dbg_addr = rd;
    #1;
    chk({tag, "_rd"}, bus.dbg_data, m_rf[rd]);
  endtask

  initial begin
    logic [3:0] vs_tab [4];
    logic [3:0] vs;
    vs_tab[0] = 4'b0001; vs_tab[1] = 4'b0010; vs_tab[2] = 4'b0100; vs_tab[3] = 4'b1000;
    rst_n = 1'b0;
    bus.start = 0; bus.rn = 0; bus.rm = 0; bus.rd = 0; bus.shift = 0; bus.aluop = 0;
    bus.asel = 0; bus.bsel = 0; bus.vsel = 0; bus.wb_en = 0; bus.ld_s = 0;
    bus.mdata = 0; bus.sximm8 = 0; bus.sximm5 = 0; bus.pc = 0; bus.dbg_addr = 0;
    for (int i = 0; i < NREG; i++) m_rf[i] = '0;
    m_c = '0; m_st = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_c", bus.c_out, 0);
    chk("rst_status", bus.status, 0);
    rst_n = 1'b1;
    check_regs("rst");

    run_op("ld_r1", 0, 0, 1, 0, 0, 0, 0, 4'b0010, 1, 0, 0, 16'h0007, 0, 0, 0);
    run_op("ld_r2", 0, 0, 2, 0, 0, 0, 0, 4'b0010, 1, 0, 0, 16'h0003, 0, 0, 0);
    run_op("add_lsl", 1, 2, 3, 2'b01, 2'b00, 0, 0, 4'b1000, 1, 1, 0, 0, 0, 0, 0);
    chk("r3_is_d", m_rf[3], 16'h000D);
    run_op("ld_7fff", 0, 0, 1, 0, 0, 0, 0, 4'b0010, 1, 0, 0, 16'h7FFF, 0, 0, 0);
    run_op("ld_one", 0, 0, 2, 0, 0, 0, 0, 4'b0010, 1, 0, 0, 16'h0001, 0, 0, 0);
    run_op("add_ovf", 1, 2, 6, 0, 2'b00, 0, 0, 4'b1000, 1, 1, 0, 0, 0, 0, 0);
    chk("ovf_status_model", m_st, 3'b110);
    run_op("sub_zero", 2, 2, 7, 0, 2'b01, 0, 0, 4'b1000, 1, 1, 0, 0, 0, 0, 0);
    run_op("bad_vsel", 1, 2, 1, 0, 2'b00, 0, 0, 4'b0011, 1, 0, 0, 16'h5555, 0, 0, 1);
    check_regs("after_err");
    run_op("pc_wb", 0, 0, 5, 0, 0, 0, 0, 4'b0100, 1, 0, 0, 0, 0, 8'hAB, 0);
    chk("r5_pc_model", m_rf[5], 16'h00AB);

    // Reset in EXE of a pending write to R4.
    @(negedge clk);
    bus.rd = 4; bus.vsel = 4'b0010; bus.sximm8 = 16'h1234; bus.wb_en = 1;
    bus.ld_s = 1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_c", bus.c_out, 0);
    chk("midrst_status", bus.status, 0);
    for (int i = 0; i < NREG; i++) m_rf[i] = '0;
    m_c = '0; m_st = '0;
    check_regs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 0, 0, 4, 0, 0, 0, 0, 4'b0010, 1, 0, 0, 16'h00C3, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      vs = ($urandom_range(0, 9) == 0) ? 4'($urandom) : vs_tab[$urandom_range(0, 3)];
      run_op($sformatf("rnd%0d", n), RAW'($urandom), RAW'($urandom), RAW'($urandom),
             2'($urandom), 2'($urandom), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 4) == 0), vs, ($urandom_range(0, 7) != 0),
             1'($urandom), W'($urandom), W'($urandom), W'($urandom), PCW'($urandom),
             ($urandom_range(0, 5) == 0));
    end
    check_regs("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/datapath_seq.md
DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 Parameter W, default 16, datapath and register width (W >= 4).
REQ-002 Parameter RAW, default 3, register-file address width; 2**RAW registers.
REQ-003 Parameter PCW, default 8, PC width (PCW <= W); zero-extended on writeback.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port start  input  1  operation request; accepted only in IDLE.
REQ-007 Port rn, rm, rd  input  RAW each  A-source, B-source and destination register.
REQ-008 Port shift  input  2  B shift: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1.
REQ-009 Port aluop  input  2  00 A+B, 01 A-B, 10 A&B, 11 ~B.
REQ-010 Port asel, bsel  input  1 each  asel=1 forces A operand to 0; bsel=1 selects sximm in place of the shifted B.
REQ-011 Port vsel  input  4  one-hot writeback select: 0001 mdata, 0010 sximm8, 0100 PC, 1000 C.
REQ-012 Port wb_en, ld_s  input  1 each  enable register writeback; enable status load.
REQ-013 Port mdata, sximm8, sximm5  input  W each  writeback and operand sources.
REQ-014 Port pc  input  PCW  program counter value.
REQ-015 Port busy  output  1  high whenever state != IDLE.
REQ-016 Port done  output  1  one-cycle pulse, high during WB.
REQ-017 Port err  output  1  one-cycle pulse, high during WB when wb_en=1 and vsel is not one-hot; no write occurs.
REQ-018 Port c_out  output  W  result register C.
REQ-019 Port status  output  3  {V,N,Z} status register.
REQ-020 Port dbg_addr  input  RAW and dbg_data  output  W  combinational read of the register file.

Function
REQ-021 FSM states IDLE, LDA, LDB, EXE, WB; transitions IDLE->LDA on start, then LDA->LDB->EXE->WB->IDLE unconditionally.
REQ-022 On start acceptance, all control and select fields are captured into an internal instruction register; input changes after acceptance do not affect the operation. mdata, sximm8, sximm5 and pc are not captured and are sampled live in the state that uses them.
REQ-023 start is ignored while busy=1; no queueing.
REQ-024 LDA: register A <= reg[rn]. LDB: register B <= reg[rm].
REQ-025 EXE: C <= ALU(Ain, Bin) truncated to W bits. Ain = asel ? 0 : A. Bin = bsel ? sximm5 : shift(B).
REQ-026 EXE with ld_s=1: Z = (result==0); N = result[W-1]; V = signed overflow for ADD/SUB, 0 for AND/NOT. Status is held when ld_s=0.
REQ-027 WB with wb_en=1 and valid vsel: reg[rd] <= selected source; the C source is the value loaded in EXE; PC is zero-extended to W.
REQ-028 Latency: start sampled high at edge t gives done high for the cycle after edge t+3; the register write lands at edge t+4; minimum issue interval is 5 cycles.
REQ-029 rd equal to rn or rm is permitted; the reads complete before WB, so the old values are used.
REQ-030 dbg_data reflects a WB write from the edge the write occurs.

Reset
REQ-031 rst_n low asynchronously sets state IDLE, all registers in the register file, A, B, C and status to 0, and busy, done and err to 0.
REQ-032 Reset during any non-IDLE state aborts the operation with no register write; the first cycle after release is IDLE and start is accepted.

Verification
REQ-033 From reset: rd=1, vsel=0010, sximm8=0x0007, wb_en=1, pulse start -> done at cycle 4; dbg_addr=1 gives 0x0007; busy high for 4 cycles.
REQ-034 R1=7, R2=3: rn=1, rm=2, shift=01, aluop=00, ld_s=1, vsel=1000, rd=3 -> c_out=0x000D; R3=0x000D; status=000.
REQ-035 R1=0x7FFF, R2=1: ADD with ld_s=1 -> c_out=0x8000; status {V,N,Z}=110. Then SUB R2-R2 -> status=001.
REQ-036 wb_en=1, vsel=0011 -> err pulses with done; no register changes. start pulsed again while busy -> ignored; exactly one done.
REQ-037 Reset asserted during EXE of a write to R4=0x1234 -> R4 stays 0; busy=0 immediately; the next start runs normally.
REQ-038 pc=0xAB, vsel=0100, rd=5 -> R5=0x00AB.
